prv32_mdu_seq: RTL and testbench
================================

Name: prv32_mdu_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer.
- Performs all eight M-extension ops by driving the core's 32-bit ALU for one add or subtract per iteration.
- Sits beside the EX stage. While it owns the ALU, EX stalls on `busy`, and the EX-side mux selects this block's `alu_*` outputs whenever `alu_own`=1.

Parameters:
- XLEN, 32, operand width; only 32 supported.
- ITERS, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- flush  in  1  abort current op; no done
- op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  dividend / multiplicand
- rs2  in  32  divisor / multiplier
- busy  out  1  op in flight
- done  out  1  one-cycle pulse; result valid that cycle
- result  out  32  result; held until next accept
- alu_own  out  1  1 while ALU borrowed (ITER state)
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_alufn  out  4  0000 add, 0001 sub
- alu_r  in  32  ALU result
- alu_cf  in  1  ALU carry; for sub, 1 = no borrow

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE; busy, done, alu_own = 0; result, alu_a, alu_b, alu_alufn = 0. Reset mid-operation discards all internal state.
- FSM: IDLE -> PRE -> ITER (x ITERS) -> POST -> DONE -> IDLE.
- Accept rule: operands and op are captured on the edge where start=1 and state=IDLE. busy=1 from the next cycle through POST.
- start while busy is ignored; it is not queued.
- PRE:
  - For signed ops, take magnitudes using a local negator; the ALU is not used.
  - Record result sign:
    - MULH: rs1[31]^rs2[31].
    - MULHSU: rs1[31].
    - DIV: rs1[31]^rs2[31].
    - REM: rs1[31].
  - Clear the 64-bit accumulator; load the counter with ITERS-1.
- ITER, multiply (per cycle):
  - alu_a=acc_hi, alu_b = mcand if mplier lsb else 0, alufn=0000.
  - acc <= {alu_cf, alu_r, acc_lo} >> 1.
  - mplier >>= 1.
- ITER, divide (per cycle):
  - rem_s = {rem[30:0], dvd[31]}, with the shifted-out bit t=rem[31].
  - alu_a=rem_s, alu_b=divisor, alufn=0001.
  - qbit = alu_cf | t.
  - rem <= qbit ? alu_r : rem_s.
  - dvd <= {dvd[30:0], qbit}.
- Counter:
  - Decrements each ITER cycle.
  - ITER -> POST when counter==0.
  - Exactly ITERS ALU cycles.
- POST: apply sign fix via the local negator (64-bit for MULH*), then select the result:
  - MUL: lo.
  - MULH*: hi.
  - DIV*: quotient.
  - REM*: remainder.
- DONE: done=1 for one cycle; busy=0; result registered. A start in this cycle is not accepted; IDLE is entered next cycle.
- Latency: accept edge to done = ITERS+3 cycles (35 by default).
- Divide by zero:
  - Quotient = 0xFFFF_FFFF, remainder = rs1.
  - Applies to both signed and unsigned variants.
- Signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF):
  - DIV = 0x8000_0000.
  - REM = 0.
- flush:
  - From any non-IDLE state, go to IDLE next cycle.
  - busy and alu_own fall that cycle; no done; result unchanged.
  - flush together with start in IDLE: flush wins, nothing accepted.
- alu_own=0 outside ITER; alu_a, alu_b, alu_alufn are driven 0 when alu_own=0.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined:
  - Divide-by-zero, signed overflow, and multiply with either operand 0 skip ITER: PRE -> POST directly.
  - done comes 3 cycles after accept; alu_own stays 0.
- When undefined:
  - These cases run the full ITERS iterations.
  - Results are identical; the special-case results are forced in POST.

Decomposition:
- Shared package prv32_mdu_pkg holds:
  - op encodings (MDU_MUL ... MDU_REMU).
  - FSM state enum.
  - ALU function constants ALUFN_ADD=4'b0000, ALUFN_SUB=4'b0001.
- One sub-module: prv32_mdu_neg, a 64-bit conditional two's-complement negator, used in PRE (low 32 bits) and POST.

Test Plan:
- MULHU, rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> result 0xFFFF_FFFE; done exactly 35 cycles after accept; alu_own high 32 cycles.
- MUL / MULH, rs1=0xFFFF_FFFD (-3), rs2=7 -> MUL 0xFFFF_FFEB; MULH 0xFFFF_FFFF. MULHSU with the same operands -> 0xFFFF_FFFF.
- DIV / REM, rs1=-7, rs2=2 -> 0xFFFF_FFFD / 0xFFFF_FFFF. DIVU / REMU, rs1=100, rs2=7 -> 14 / 2.
- DIV rs1=5, rs2=0 -> 0xFFFF_FFFF; REM -> 5. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0. With MDU_EARLY_OUT_EN, done 3 cycles after accept.
- start pulsed at cycle 10 of a busy op -> ignored; flush at iteration 5 -> busy=0 next cycle, no done, result holds its old value; a new start then completes correctly.
- rst_n asserted mid-ITER -> all outputs 0 immediately; after release, a new op runs to a correct result.

Source files
------------

// File: rtl/prv32_mdu_pkg.sv
// prv32_mdu_pkg: shared definitions for the RV32M multiply/divide sequencer.
//   - op encodings as presented on the sequencer's op port
//   - FSM state encoding
//   - ALU function codes driven on alu_alufn
//   - small op-class decode helpers
package prv32_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef logic [2:0] mdu_state_t;

  localparam mdu_state_t ST_IDLE = 3'd0;
  localparam mdu_state_t ST_PRE  = 3'd1;
  localparam mdu_state_t ST_ITER = 3'd2;
  localparam mdu_state_t ST_POST = 3'd3;
  localparam mdu_state_t ST_DONE = 3'd4;

  localparam logic [3:0] ALUFN_ADD = 4'b0000;
  localparam logic [3:0] ALUFN_SUB = 4'b0001;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic mdu_rs1_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic mdu_rs2_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/prv32_mdu_neg.sv
// prv32_mdu_neg: conditional two's-complement negator.
// Ports:
//   en  in  1  1 = output -a, 0 = output a
//   a   in  W  operand
//   y   out W  result
module prv32_mdu_neg #(
  parameter int unsigned W = 64
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/prv32_mdu_seq.sv
// prv32_mdu_seq: multi-cycle RV32M multiply/divide sequencer.
// Borrows the core ALU for one add (multiply) or subtract (divide) per iteration;
// sign handling uses local negators so the ALU is only owned during ITER.
// FSM: IDLE -> PRE -> ITER (x ITERS) -> POST -> DONE -> IDLE.
// Build option: define MDU_EARLY_OUT_EN to send divide-by-zero, signed overflow and
// multiply-by-zero straight from PRE to POST (done 3 cycles after accept).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request and opcode; accepted only in IDLE without flush
//   flush             abort current op, no done
//   rs1, rs2          operands
//   busy, done        op in flight / one-cycle completion pulse
//   result            registered result, held until the next completion
//   alu_own           ALU borrowed (ITER); alu_a/alu_b/alu_alufn are 0 otherwise
//   alu_a, alu_b      ALU operands
//   alu_alufn         ALU function (add/sub)
//   alu_r, alu_cf     ALU result and carry (for sub, 1 = no borrow)
module prv32_mdu_seq
  import prv32_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_alufn,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf
);

  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;

  mdu_state_t          state_q, state_d;
  logic [2:0]          op_q;
  // x_q: raw rs1, then |rs1|; multiplicand, or dividend shifting into quotient.
  // y_q: raw rs2, then |rs2|; multiplier shifting right, or divisor.
  logic [XLEN-1:0]     x_q, y_q;
  logic [XLEN-1:0]     rs1_q;
  // Multiply: 64-bit product. Divide: upper half is the partial remainder.
  logic [2*XLEN-1:0]   acc_q;
  logic [CntW-1:0]     cnt_q;
  logic                sign_q, dz_q, ovf_q, mz_q;
  logic [XLEN-1:0]     result_q;

  logic                is_div, is_rem, mul_hi;
  logic                pre_sign, pre_dz, pre_ovf, pre_mz, early;
  logic                neg_a_en;
  logic [2*XLEN-1:0]   neg_a_in, neg_a_y;
  logic [XLEN-1:0]     neg_b_y;
  logic [XLEN-1:0]     rem_s, post_res;
  logic                rem_t, qbit;

  assign is_div = op_q[2];
  assign is_rem = op_q[2] & op_q[1];
  assign mul_hi = ~op_q[2] & (op_q[1:0] != 2'b00);

  // Special-case detection on the raw operands still held in x_q/y_q during PRE.
  assign pre_dz  = is_div & (y_q == '0);
  assign pre_ovf = ((op_q == MDU_DIV) || (op_q == MDU_REM)) &&
                   (x_q == {1'b1, {(XLEN-1){1'b0}}}) && (y_q == '1);
  assign pre_mz  = ~is_div & ((x_q == '0) | (y_q == '0));

`ifdef MDU_EARLY_OUT_EN
  assign early = pre_dz | pre_ovf | pre_mz;
`else
  assign early = 1'b0;
`endif

  always_comb begin
    pre_sign = 1'b0;
    case (op_q)
      MDU_MULH, MDU_DIV:  pre_sign = x_q[XLEN-1] ^ y_q[XLEN-1];
      MDU_MULHSU, MDU_REM: pre_sign = x_q[XLEN-1];
      default:            pre_sign = 1'b0;
    endcase
  end

  // Shared negator: rs1 magnitude in PRE, final sign fix in POST.
  always_comb begin
    if (state_q == ST_POST) begin
      neg_a_en = sign_q;
      if (is_div) neg_a_in = {{XLEN{1'b0}}, (is_rem ? acc_q[2*XLEN-1:XLEN] : x_q)};
      else        neg_a_in = acc_q;
    end else begin
      neg_a_en = mdu_rs1_signed(op_q) & x_q[XLEN-1];
      neg_a_in = {{XLEN{1'b0}}, x_q};
    end
  end

  prv32_mdu_neg #(.W(2*XLEN)) u_neg_a (
    .en (neg_a_en),
    .a  (neg_a_in),
    .y  (neg_a_y)
  );

  prv32_mdu_neg #(.W(XLEN)) u_neg_b (
    .en (mdu_rs2_signed(op_q) & y_q[XLEN-1]),
    .a  (y_q),
    .y  (neg_b_y)
  );

  // Restoring-division step; the bit shifted out of rem forces a subtract.
  assign rem_s = {acc_q[2*XLEN-2:XLEN], x_q[XLEN-1]};
  assign rem_t = acc_q[2*XLEN-1];
  assign qbit  = alu_cf | rem_t;

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_alufn = ALUFN_ADD;
    if (state_q == ST_ITER) begin
      if (is_div) begin
        alu_a     = rem_s;
        alu_b     = y_q;
        alu_alufn = ALUFN_SUB;
      end else begin
        alu_a     = acc_q[2*XLEN-1:XLEN];
        alu_b     = y_q[0] ? x_q : '0;
        alu_alufn = ALUFN_ADD;
      end
    end
  end

  always_comb begin
    if (is_div)      post_res = neg_a_y[XLEN-1:0];
    else if (mul_hi) post_res = neg_a_y[2*XLEN-1:XLEN];
    else             post_res = neg_a_y[XLEN-1:0];
    if (dz_q)       post_res = is_rem ? rs1_q : '1;
    else if (ovf_q) post_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (mz_q)  post_res = '0;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_PRE;
        ST_PRE:  state_d = early ? ST_POST : ST_ITER;
        ST_ITER: if (cnt_q == '0) state_d = ST_POST;
        ST_POST: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rs1_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      mz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q <= op;
            x_q  <= rs1;
            y_q  <= rs2;
          end
        end
        ST_PRE: begin
          rs1_q  <= x_q;
          x_q    <= neg_a_y[XLEN-1:0];
          y_q    <= neg_b_y;
          sign_q <= pre_sign;
          dz_q   <= pre_dz;
          ovf_q  <= pre_ovf;
          mz_q   <= pre_mz;
          acc_q  <= '0;
          cnt_q  <= CntW'(ITERS - 1);
        end
        ST_ITER: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_div) begin
            acc_q[2*XLEN-1:XLEN] <= qbit ? alu_r : rem_s;
            x_q                  <= {x_q[XLEN-2:0], qbit};
          end else begin
            acc_q <= {alu_cf, alu_r, acc_q[XLEN-1:1]};
            y_q   <= y_q >> 1;
          end
        end
        ST_POST: begin
          if (!flush) result_q <= post_res;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state_q == ST_PRE) || (state_q == ST_ITER) || (state_q == ST_POST);
  assign done    = (state_q == ST_DONE);
  assign alu_own = (state_q == ST_ITER);
  assign result  = result_q;

endmodule

// File: tb/tb_prv32_mdu_seq.sv
// tb_prv32_mdu_seq: directed bench for prv32_mdu_seq with a behavioural ALU,
// an arithmetic reference model and a per-cycle compare process.
module tb_prv32_mdu_seq;
  import prv32_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done, alu_own, alu_cf;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_alufn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prv32_mdu_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_own   (alu_own),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_alufn (alu_alufn),
    .alu_r     (alu_r),
    .alu_cf    (alu_cf)
  );

  // Core ALU stand-in.
  logic [32:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    if (alu_alufn == 4'b0000)      alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_alufn == 4'b0001) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
    alu_r  = alu_wide[31:0];
    alu_cf = (alu_alufn == 4'b0001) ? ~alu_wide[32] : alu_wide[32];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // RV32M semantics in plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    pu = {32'b0, a} * {32'b0, b};
    p  = 0;
    case (o)
      MDU_MUL:    begin p = sa * sb; return p[31:0]; end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  return pu[63:32];
      MDU_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_early(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (o[2]) return (b == 0) ||
                     ((o == MDU_DIV || o == MDU_REM) && a == 32'h8000_0000 && b == '1);
    return (a == 0) || (b == 0);
`else
    return (o == 3'b000) && (a == 32'h1) && (b == 32'h1) && 1'b0;
`endif
  endfunction

  // Reference model: m_age counts cycles since the accept edge.
  bit          m_act = 1'b0;
  bit          m_div = 1'b0;
  int          m_age = 0;
  int          m_lat = 35;
  logic [31:0] m_exp = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_res <= '0;
    end else if (m_act) begin
      if (flush) begin
        m_act <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age + 1 == m_lat - 1) m_res <= m_exp;
        if (m_age + 1 == m_lat) m_act <= 1'b0;
      end
    end else if (start && !flush) begin
      m_act <= 1'b1;
      m_age <= 0;
      m_div <= op[2];
      m_exp <= ref_res(op, rs1, rs2);
      m_lat <= ref_early(op, rs1, rs2) ? 3 : 35;
    end
  end

  logic exp_busy, exp_done, exp_own;
  assign exp_busy = m_act && (m_age <= m_lat - 2);
  assign exp_done = m_act && (m_age == m_lat - 1);
  assign exp_own  = m_act && (m_lat == 35) && (m_age >= 1) && (m_age <= 32);

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("alu_own", {31'b0, alu_own}, {31'b0, exp_own});
    chk("result", result, m_res);
    if (!alu_own) begin
      chk("alu_a idle", alu_a, 32'h0);
      chk("alu_b idle", alu_b, 32'h0);
      chk("alufn idle", {28'b0, alu_alufn}, 32'h0);
    end else begin
      chk("alufn iter", {28'b0, alu_alufn}, m_div ? 32'h1 : 32'h0);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input bit special,
                        input int pulse_at);
    int n;
    int own;
    int lat;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    own = 0;
    while (!done && n < 100) begin
      if (alu_own) own++;
      if (n == pulse_at) begin
        start = 1'b1; op = MDU_DIV; rs1 = 32'd5; rs2 = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
`ifdef MDU_EARLY_OUT_EN
    lat = special ? 3 : 35;
`else
    lat = (special && 1'b0) ? 3 : 35;
`endif
    chk({nm, " latency"}, n, lat);
    chk({nm, " own cycles"}, own, (lat == 35) ? 32 : 0);
    chk({nm, " result"}, result, lit);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int seen;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset alu_own", {31'b0, alu_own}, 32'h0);

    // Start pulsed at cycle 10 of a busy op must be dropped.
    run_op("mulhu", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 10);
    @(negedge clk);
    @(negedge clk);
    chk("busy start ignored", {31'b0, busy}, 32'h0);

    run_op("mul",    MDU_MUL,    32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("mulh",   MDU_MULH,   32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 1'b0, 0);

    // Flush at iteration 5.
    @(negedge clk);
    op = MDU_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'h0);
    seen = 0;
    repeat (45) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    chk("flush no done", seen, 0);
    chk("flush result held", result, 32'hFFFF_FFFF);

    run_op("div",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("rem",  MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
    run_op("remu", MDU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 0);
    run_op("div0",  MDU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("rem0",  MDU_REM,  32'd5, 32'd0, 32'd5, 1'b1, 0);
    run_op("divu0", MDU_DIVU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("rem0n", MDU_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, 0);
    run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0);
    run_op("removf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    run_op("mulz",   MDU_MULH, 32'h1234_5678, 32'd0, 32'h0, 1'b1, 0);

    // flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    op = MDU_MUL; rs1 = 32'd2; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush beats start", {31'b0, busy}, 32'h0);

    // Reset mid-ITER.
    @(negedge clk);
    op = MDU_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    chk("rst alu_own", {31'b0, alu_own}, 32'h0);
    chk("rst result", result, 32'h0);
    chk("rst alu_a", alu_a, 32'h0);
    chk("rst alu_b", alu_b, 32'h0);
    chk("rst alufn", {28'b0, alu_alufn}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("after rst", MDU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
